sico_sync_resp: RTL
===================

SICO_SYNC_RESP -- requirements
Module: sico_sync_resp

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of the cycle counter and its report.
REQ-002 SHALL have parameter RESET_CYCLES, default 16: number of clk_i cycles rst_dut_no stays low after rst_ni deasserts (legal range 1..255).
REQ-003 SHALL have port clk_i, input, 1: the single clock; all logic is in this domain.
REQ-004 SHALL have port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port tick_i, input, 1: one-cycle pulse marking each co-simulation update point.
REQ-006 SHALL have port hold_i, input, 1: level request from the co-simulation host to stall the DUT.
REQ-007 SHALL have port run_o, output, 1: clock enable for the DUT.
REQ-008 SHALL have port rst_dut_no, output, 1: active-low DUT reset with stretched, synchronous release.
REQ-009 SHALL have port cnt_o, output, CNT_W: run cycles counted between two consecutive ticks.
REQ-010 SHALL have port cnt_valid_o, output, 1: cnt_o holds a report.
REQ-011 SHALL have port cnt_ready_i, input, 1: consumer accepts the report.
REQ-012 SHALL have port ovf_o, output, 1: sticky flag, counter saturated.
REQ-013 SHALL have port drop_o, output, 1: one-cycle pulse, report lost.

Function
REQ-014 FSM states SHALL be RST_SEQ, RUN and HOLD.
REQ-015 RST_SEQ SHALL count RESET_CYCLES cycles, then release rst_dut_no to 1 and go to RUN on the next edge.
REQ-016 RUN SHALL go to HOLD in the cycle after hold_i is sampled high; HOLD SHALL return to RUN in the cycle after hold_i is sampled low.
REQ-017 run_o SHALL be 1 only in RUN, registered, with no combinational path from hold_i.
REQ-018 The cycle counter SHALL increment once per cycle with run_o=1, saturate at 2^CNT_W-1, and set ovf_o on reaching saturation.
REQ-019 A tick_i sampled in RUN or HOLD SHALL load the counter value (including the tick cycle's own increment) into cnt_o, raise cnt_valid_o, and restart the counter at 0 on the next cycle.
REQ-020 cnt_o and cnt_valid_o SHALL stay stable while cnt_valid_o=1 and cnt_ready_i=0, and SHALL clear in the cycle after a valid&&ready handshake.
REQ-021 If a tick arrives in the same cycle as the handshake, the new report SHALL be loaded and cnt_valid_o SHALL remain 1.
REQ-022 If a tick arrives while a report is pending without a handshake, cnt_o SHALL keep the old value, drop_o SHALL pulse for 1 cycle, and the counter SHALL still restart.
REQ-023 tick_i in RST_SEQ SHALL be ignored without setting drop_o.
REQ-024 ovf_o SHALL clear only on rst_ni.

Reset
REQ-025 While rst_ni=0, outputs SHALL be: run_o=0, rst_dut_no=0, cnt_o=0, cnt_valid_o=0, ovf_o=0, drop_o=0, and the state SHALL be RST_SEQ.
REQ-026 Assertion of rst_ni mid-report or mid-hold SHALL discard all state immediately, and a full RST_SEQ SHALL follow.

Configuration
REQ-027 With SICO_SYNC_STATS_EN defined, the block SHALL add outputs tick_cnt_o[31:0] (ticks accepted) and drop_cnt_o[15:0] (drops); both SHALL saturate and reset to 0.
REQ-028 Without SICO_SYNC_STATS_EN, those ports and their counters SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-029 Package sico_sync_pkg SHALL hold the state enum and the RESET_CYCLES counter width constant (8).
REQ-030 Sub-module sico_rst_seq SHALL implement the RESET_CYCLES reset stretcher that drives rst_dut_no.

Verification
REQ-031 Bench SHALL cover: rst_ni low for 3 cycles then high, RESET_CYCLES=16 -> rst_dut_no rises exactly 16 cycles after release, and run_o rises 1 cycle later.
REQ-032 Bench SHALL cover: ticks 100 cycles apart, cnt_ready_i=1 -> cnt_o=100 each report, drop_o never pulses.
REQ-033 Bench SHALL cover: hold_i high for 20 cycles inside a 100-cycle tick interval -> run_o low for 20 cycles, cnt_o=80.
REQ-034 Bench SHALL cover: cnt_ready_i=0 across two ticks -> first cnt_o retained, drop_o pulses once; with STATS_EN, drop_cnt_o=1.
REQ-035 Bench SHALL cover: CNT_W=4, ticks 30 cycles apart -> cnt_o=15 and ovf_o stays 1 until rst_ni.
REQ-036 Bench SHALL cover: tick coinciding with a handshake -> new cnt_o loaded, cnt_valid_o stays 1, no drop.

Source files
------------

// File: rtl/sico_sync_pkg.sv
// rtl/sico_sync_pkg.sv - shared state type and constants for the co-simulation sync responder
package sico_sync_pkg;

  // Top-level sequencing states of the responder
  typedef enum logic [1:0] {
    RST_SEQ = 2'd0,
    RUN     = 2'd1,
    HOLD    = 2'd2
  } sync_state_e;

  // Width of the reset-stretch counter; bounds RESET_CYCLES to 1..255
  localparam int unsigned RST_CNT_W = 8;

endpackage

// File: rtl/sico_rst_seq.sv
// rtl/sico_rst_seq.sv - stretches rst_ni into a synchronously released DUT reset
module sico_rst_seq
  import sico_sync_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic rst_dut_no
);

  // Counter value seen on the last stretched cycle; the release edge follows it
  localparam logic [RST_CNT_W-1:0] LAST_CNT = RST_CNT_W'(RESET_CYCLES - 1);

  logic [RST_CNT_W-1:0] cnt_q, cnt_d;
  logic                 done_q, done_d;

  // Count clk_i edges after reset release and latch done once RESET_CYCLES have passed
  always_comb begin
    cnt_d  = cnt_q;
    done_d = done_q;
    if (!done_q) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST_CNT) begin
        done_d = 1'b1;
      end
    end
  end

  // Stretch counter and release flag; both restart whenever rst_ni asserts
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign rst_dut_no = done_q;

endmodule

// File: rtl/sico_sync_resp.sv
// rtl/sico_sync_resp.sv - co-simulation sync responder top; SICO_SYNC_STATS_EN adds tick/drop statistics
module sico_sync_resp
  import sico_sync_pkg::*;
#(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned RESET_CYCLES = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             tick_i,
  input  logic             hold_i,
  output logic             run_o,
  output logic             rst_dut_no,
  output logic [CNT_W-1:0] cnt_o,
  output logic             cnt_valid_o,
  input  logic             cnt_ready_i,
  output logic             ovf_o,
  output logic             drop_o
`ifdef SICO_SYNC_STATS_EN
  ,
  output logic [31:0]      tick_cnt_o,
  output logic [15:0]      drop_cnt_o
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  sync_state_e      state_q, state_d;
  logic             run_q, run_d;
  logic [CNT_W-1:0] cyc_q, cyc_d, cyc_inc;
  logic [CNT_W-1:0] rpt_q, rpt_d;
  logic             rpt_valid_q, rpt_valid_d;
  logic             ovf_q, ovf_d;
  logic             drop_q, drop_d;
  logic             rst_done;
  logic             tick_acc;
  logic             handshake;
  logic             drop_evt;

  sico_rst_seq #(
    .RESET_CYCLES(RESET_CYCLES)
  ) u_rst_seq (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .rst_dut_no(rst_done)
  );

  // Ticks count only once the DUT is out of reset; a tick meeting a pending,
  // unaccepted report is lost, but the counter still restarts.
  assign tick_acc  = tick_i && (state_q != RST_SEQ);
  assign handshake = rpt_valid_q && cnt_ready_i;
  assign drop_evt  = tick_acc && rpt_valid_q && !cnt_ready_i;
  assign cyc_inc   = (run_q && (cyc_q != CNT_MAX)) ? cyc_q + 1'b1 : cyc_q;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RST_SEQ;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: leave reset when the stretcher releases, then follow hold_i
  always_comb begin
    state_d = state_q;
    case (state_q)
      RST_SEQ: if (rst_done) state_d = RUN;
      RUN:     if (hold_i)   state_d = HOLD;
      HOLD:    if (!hold_i)  state_d = RUN;
      default:               state_d = RST_SEQ;
    endcase
  end

  // Output decode from next state so run_o is a flop with no path from hold_i
  always_comb begin
    run_d = (state_d == RUN);
  end

  // Counter, report and flag next values
  always_comb begin
    cyc_d       = tick_acc ? '0 : cyc_inc;
    ovf_d       = ovf_q || (run_q && (cyc_inc == CNT_MAX));
    drop_d      = drop_evt;
    rpt_d       = rpt_q;
    rpt_valid_d = rpt_valid_q;
    if (tick_acc && !drop_evt) begin
      rpt_d       = cyc_inc;
      rpt_valid_d = 1'b1;
    end else if (handshake) begin
      rpt_d       = '0;
      rpt_valid_d = 1'b0;
    end
  end

  // Datapath registers: run enable, cycle counter, report and status flags
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_q       <= 1'b0;
      cyc_q       <= '0;
      rpt_q       <= '0;
      rpt_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      run_q       <= run_d;
      cyc_q       <= cyc_d;
      rpt_q       <= rpt_d;
      rpt_valid_q <= rpt_valid_d;
      ovf_q       <= ovf_d;
      drop_q      <= drop_d;
    end
  end

  assign run_o       = run_q;
  assign rst_dut_no  = rst_done;
  assign cnt_o       = rpt_q;
  assign cnt_valid_o = rpt_valid_q;
  assign ovf_o       = ovf_q;
  assign drop_o      = drop_q;

`ifdef SICO_SYNC_STATS_EN
  logic [31:0] tick_cnt_q, tick_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Saturating counts of accepted ticks and lost reports
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (tick_acc && (tick_cnt_q != '1)) tick_cnt_d = tick_cnt_q + 1'b1;
    if (drop_evt && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 1'b1;
  end

  // Statistics registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tick_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign tick_cnt_o = tick_cnt_q;
  assign drop_cnt_o = drop_cnt_q;
`endif

endmodule
